// File: rtl/lfsr_word_buffer.sv
// lfsr_word_buffer
//   Prefetch buffer sitting directly behind a 128-bit LFSR. It drives the LFSR
//   control inputs, seeds it after reset or on request, and steps it only while
//   a FIFO slot is free. Each stepped state word is captured into a DEPTH-entry
//   FIFO and handed to the consumer over a valid/ready handshake.
//
//   Optional feature: define LFSR_LOCKUP_CHECK_EN to drop all-ones (XNOR
//   lock-up) words, raise sticky o_Lockup and reload the current seed.
//   Without the macro all-ones words pass through and o_Lockup is tied 0.
//
// Ports
//   i_Clk, i_Rst        clock, synchronous active-high reset
//   o_LFSR_Enable       LFSR i_Enable
//   o_LFSR_Seed_DV      LFSR i_Seed_DV (one-cycle pulse per seed load)
//   o_LFSR_Seed_Data    LFSR i_Seed_Data, held between seeds
//   i_LFSR_Data         LFSR state word
//   i_LFSR_Done         LFSR back at its seed
//   i_Reseed            one-cycle reseed request, seed taken from i_Seed_Data
//   i_Seed_Data         new seed
//   o_Rand_Data         FIFO head word (0 when empty)
//   o_Rand_Valid        head word valid
//   i_Rand_Ready        consumer accepts head word
//   o_Period_Wrap       sticky: LFSR returned to its seed
//   o_Lockup            sticky: all-ones word seen (macro builds only)
module lfsr_word_buffer #(
  parameter int                  NUM_BITS = 128,
  parameter int                  DEPTH    = 4,
  parameter logic [NUM_BITS-1:0] SEED     = NUM_BITS'(1)
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  output logic                o_LFSR_Enable,
  output logic                o_LFSR_Seed_DV,
  output logic [NUM_BITS-1:0] o_LFSR_Seed_Data,
  input  logic [NUM_BITS-1:0] i_LFSR_Data,
  input  logic                i_LFSR_Done,
  input  logic                i_Reseed,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_Rand_Data,
  output logic                o_Rand_Valid,
  input  logic                i_Rand_Ready,
  output logic                o_Period_Wrap,
  output logic                o_Lockup
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] seed_q, seed_d;
  logic                step_q, step_d;
  logic                wrap_q, wrap_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BITS-1:0] mem_q [DEPTH];
  logic                lockup_hit, wr_en, rd_en, room;

  // A step is only allowed if the word it produces already has a slot, so
  // the in-flight capture counts as occupied. Pops this cycle are not
  // credited; stepping resumes the cycle after the pop.
  assign room = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, step_q}) < DEPTH_V;

`ifdef LFSR_LOCKUP_CHECK_EN
  logic lock_q, lock_d;
  assign lockup_hit = step_q && (&i_LFSR_Data);
  assign lock_d     = i_Reseed ? 1'b0 : (lock_q | lockup_hit);
  always_ff @(posedge i_Clk) begin
    if (i_Rst) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end
  assign o_Lockup = lock_q;
`else
  assign lockup_hit = 1'b0;
  assign o_Lockup   = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    seed_d         = seed_q;
    step_d         = 1'b0;
    wrap_d         = wrap_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    cnt_d          = cnt_q;
    o_LFSR_Enable  = 1'b0;
    o_LFSR_Seed_DV = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_SEED;
      S_SEED: begin
        o_LFSR_Enable  = 1'b1;
        o_LFSR_Seed_DV = 1'b1;
        state_d        = S_RUN;
      end
      S_RUN: begin
        if (room && !i_Reseed && !lockup_hit) begin
          o_LFSR_Enable = 1'b1;
          step_d        = 1'b1;
        end
        // Locked LFSR: stop stepping and reload the seed we already hold.
        if (lockup_hit) state_d = S_SEED;
      end
      default: state_d = S_IDLE;
    endcase

    wr_en = step_q && !lockup_hit;
    rd_en = o_Rand_Valid && i_Rand_Ready;
    if (step_q && i_LFSR_Done) wrap_d = 1'b1;

    if (i_Reseed) begin
      // Flush wins over any capture or pop in the same cycle.
      state_d  = S_SEED;
      seed_d   = i_Seed_Data;
      step_d   = 1'b0;
      wrap_d   = 1'b0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= S_IDLE;
      seed_q   <= SEED;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by cnt_q alone.
  always_ff @(posedge i_Clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_LFSR_Data;
  end

  assign o_Rand_Valid     = (cnt_q != '0);
  assign o_Rand_Data      = o_Rand_Valid ? mem_q[rd_ptr_q] : '0;
  assign o_LFSR_Seed_Data = seed_q;
  assign o_Period_Wrap    = wrap_q;

endmodule

// File: tb/tb_lfsr_word_buffer.sv
module tb_lfsr_word_buffer;

  localparam logic [127:0] SEED_V  = 128'h1;
  localparam logic [127:0] ALL_ONE = {128{1'b1}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         lfsr_en, lfsr_seed_dv, lfsr_done;
  logic [127:0] lfsr_seed;
  logic [127:0] lfsr_q = '0;
  logic         force_done = 1'b0;
  logic         reseed = 1'b0;
  logic [127:0] seed_in = '0;
  logic [127:0] rand_data;
  logic         rand_valid;
  logic         rand_ready = 1'b0;
  logic         period_wrap, lockup;

  int checks = 0;
  int failures = 0;
  int delivered = 0;

  always #5 clk = ~clk;

  // Reference LFSR: XNOR feedback from taps 128,126,101,99, shift toward MSB.
  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return {s[126:0], ~(s[127] ^ s[125] ^ s[100] ^ s[98])};
  endfunction

  always @(posedge clk)
    if (lfsr_en) lfsr_q <= lfsr_seed_dv ? lfsr_seed : lfsr_step(lfsr_q);
  assign lfsr_done = (lfsr_q == lfsr_seed) | force_done;

  lfsr_word_buffer dut (
    .i_Clk            (clk),
    .i_Rst            (rst),
    .o_LFSR_Enable    (lfsr_en),
    .o_LFSR_Seed_DV   (lfsr_seed_dv),
    .o_LFSR_Seed_Data (lfsr_seed),
    .i_LFSR_Data      (lfsr_q),
    .i_LFSR_Done      (lfsr_done),
    .i_Reseed         (reseed),
    .i_Seed_Data      (seed_in),
    .o_Rand_Data      (rand_data),
    .o_Rand_Valid     (rand_valid),
    .i_Rand_Ready     (rand_ready),
    .o_Period_Wrap    (period_wrap),
    .o_Lockup         (lockup)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Stream model: the k-th accepted word after a seed is the LFSR stepped k
  // times from that seed; the head must not change while stalled.
  logic [127:0] exp_state = SEED_V;
  logic [127:0] hold_word = '0;
  logic         hold_pending = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_state    = SEED_V;
      hold_pending = 1'b0;
    end else if (reseed) begin
      exp_state    = seed_in;
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && rand_valid) chk("hold_stable", rand_data, hold_word);
      if (rand_valid && rand_ready) begin
        exp_state = lfsr_step(exp_state);
        chk("stream_word", rand_data, exp_state);
        delivered++;
      end
      hold_pending = rand_valid && !rand_ready;
      hold_word    = rand_data;
    end
  end

  task automatic do_reset();
    rst    = 1'b1;
    reseed = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int pulses, d0, vcnt;

    // Reset release with ready high: timing and words 1..8 from seed 1.
    rand_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chkb("rst_enable", lfsr_en, 1'b0);
    chkb("rst_seed_dv", lfsr_seed_dv, 1'b0);
    chkb("rst_valid", rand_valid, 1'b0);
    chkb("rst_wrap", period_wrap, 1'b0);
    chkb("rst_lockup", lockup, 1'b0);
    chk ("rst_seed_data", lfsr_seed, SEED_V);
    chk ("rst_rand_data", rand_data, 128'h0);
    @(negedge clk);
    chkb("n1_seed_dv", lfsr_seed_dv, 1'b1);
    chkb("n1_enable", lfsr_en, 1'b1);
    @(negedge clk);
    chkb("n2_seed_dv", lfsr_seed_dv, 1'b0);
    chkb("n2_enable", lfsr_en, 1'b1);
    chkb("n2_valid", rand_valid, 1'b0);
    @(negedge clk);
    chkb("n3_valid", rand_valid, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chkb("word_valid", rand_valid, 1'b1);
      chk ("word_literal", rand_data, (128'd1 << (k + 1)) - 128'd1);
    end

    // Ready low: exactly DEPTH steps, then stall; drain without loss.
    rand_ready = 1'b0;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lfsr_en && !lfsr_seed_dv) pulses++;
    end
    chk ("stall_pulses", 128'(pulses), 128'd4);
    chkb("stall_enable", lfsr_en, 1'b0);
    chkb("stall_valid", rand_valid, 1'b1);
    chk ("stall_head", rand_data, 128'h3);
    @(posedge clk); #1 rand_ready = 1'b1;
    d0 = delivered;
    repeat (12) @(posedge clk);
    #1;
    chk("drain_count", 128'(delivered - d0), 128'd12);

    // Random ready for 1000 cycles.
    d0 = delivered;
    for (int i = 0; i < 1000; i++) begin
      rand_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    chkb("random_progress", (delivered - d0) > 300, 1'b1);

    // Reseed with 5 while three words are buffered.
    rand_ready = 1'b0;
    do_reset();
    repeat (6) @(posedge clk);
    #1 reseed = 1'b1; seed_in = 128'h5;
    @(negedge clk);
    chkb("pre_reseed_valid", rand_valid, 1'b1);
    @(posedge clk); #1 reseed = 1'b0; rand_ready = 1'b1;
    @(negedge clk);
    chkb("r1_valid", rand_valid, 1'b0);
    chkb("r1_wrap", period_wrap, 1'b0);
    chk ("r1_seed_data", lfsr_seed, 128'h5);
    chkb("r1_seed_dv", lfsr_seed_dv, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chkb("r3_valid", rand_valid, 1'b0);
    @(negedge clk);
    chkb("r4_valid", rand_valid, 1'b1);
    chk ("r4_word", rand_data, 128'hB);
    @(negedge clk);
    chk ("r5_word", rand_data, 128'h17);

    // Forced Done on a capture cycle sets the sticky wrap flag.
    repeat (3) @(posedge clk);
    #1 force_done = 1'b1;
    @(negedge clk);
    chkb("wrap_before", period_wrap, 1'b0);
    @(posedge clk); #1 force_done = 1'b0;
    @(negedge clk);
    chkb("wrap_set", period_wrap, 1'b1);
    repeat (4) @(negedge clk);
    chkb("wrap_sticky", period_wrap, 1'b1);

    // Reseed with all ones: lock-up behaviour depends on the build.
    @(posedge clk); #1 reseed = 1'b1; seed_in = ALL_ONE;
    @(posedge clk); #1 reseed = 1'b0;
    @(negedge clk);
    chkb("lk_wrap_cleared", period_wrap, 1'b0);
    chkb("lk_seed_dv", lfsr_seed_dv, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
`ifdef LFSR_LOCKUP_CHECK_EN
    chkb("lk_lockup", lockup, 1'b1);
    chkb("lk_reseed_pulse", lfsr_seed_dv, 1'b1);
    chkb("lk_valid", rand_valid, 1'b0);
`else
    chkb("lk_lockup", lockup, 1'b0);
    chkb("lk_valid", rand_valid, 1'b1);
    chk ("lk_word", rand_data, ALL_ONE);
`endif
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rand_valid) vcnt++;
    end
`ifdef LFSR_LOCKUP_CHECK_EN
    chk("lk_no_words", 128'(vcnt), 128'd0);
`else
    chk("lk_words", 128'(vcnt), 128'd10);
`endif

    // Recover with a normal seed; lock-up flag clears.
    @(posedge clk); #1 reseed = 1'b1; seed_in = 128'h5;
    @(posedge clk); #1 reseed = 1'b0;
    @(negedge clk);
    chkb("rec_lockup", lockup, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rec_word", rand_data, 128'hB);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
